mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit words stored; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 1, wait states inserted between request acceptance and response; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  response is valid.
REQ-011 rsp_ready  input  1  initiator accepts the response.
REQ-012 rsp_rdata  output  32  read data; 0 for writes.
REQ-013 rsp_err  output  1  access fault; only active with MEM_RESP_ERR_EN.

Function
REQ-014 FSM states: IDLE, WAIT, RESP.
REQ-015 IDLE: req_ready=1; req_valid=1 accepts the request and latches write, addr and wdata.
- WAIT_CYCLES=0: next state RESP.
- otherwise: next state WAIT.
REQ-016 WAIT: req_ready=0; the counter loads WAIT_CYCLES-1 on acceptance and decrements each cycle; at 0, next state RESP.
REQ-017 Transition into RESP: the write commits to mem[idx], or the read captures mem[idx] into rsp_rdata; rsp_valid=1 from the first RESP cycle.
REQ-018 RESP: rsp_valid, rsp_rdata and rsp_err hold stable until rsp_ready=1, then next state IDLE; req_ready stays 0 throughout RESP.
REQ-019 Accepted-to-response latency is exactly WAIT_CYCLES+1 cycles when rsp_ready is held at 1; back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
REQ-020 Word index idx = req_addr[log2(DEPTH_WORDS)+1:2]; req_addr[1:0] and the upper bits are ignored (wrap modulo DEPTH_WORDS) unless REQ-026 applies.
REQ-021 A read of a word written by the immediately preceding transaction returns the new data.
REQ-022 req_valid in WAIT or RESP is ignored; inputs are sampled only in IDLE.
REQ-023 Reset asserted mid-transaction aborts it: state returns to IDLE, an uncommitted write is discarded, and no response is produced.

Reset
REQ-024 During reset: state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; latched request fields clear to 0.
REQ-025 Storage contents are not reset; a read before any write returns an undefined value, which the bench treats as don't-care.

Configuration
REQ-026 Macro MEM_RESP_ERR_EN defined: an access faults if req_addr[1:0]!=0 or req_addr>=4*DEPTH_WORDS.
- Fault response: rsp_err=1, rsp_rdata=0, write suppressed.
- Timing is identical to a normal access.
REQ-027 Macro MEM_RESP_ERR_EN undefined: rsp_err is constant 0, no fault checking exists, and REQ-020 wrap applies.

Structure
REQ-028 riscv_pkg holds the FSM enum mem_resp_state_e (IDLE, WAIT, RESP) and the localparam for the counter width (4).
REQ-029 The storage is a sub-module mem_array: single port, synchronous write, combinational read, parameter DEPTH_WORDS. mem_responder holds the FSM, counter, request latches and fault logic.

Verification
REQ-030 WAIT_CYCLES=1: write 0xDEADBEEF to 0x10, then read 0x10, rsp_ready=1 -> rsp_valid 2 cycles after each acceptance; the read returns 0xDEADBEEF.
REQ-031 WAIT_CYCLES=0: read 0x10 then read 0x14 back-to-back -> one response each, at 1-cycle latency; req_ready=0 during RESP.
REQ-032 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata are stable; a req_valid pulse is ignored; IDLE follows the cycle after rsp_ready=1.
REQ-033 DEPTH_WORDS=64: write 0x12345678 to 0x100 (wraps to word 0), then read 0x0.
- MEM_RESP_ERR_EN off -> read returns 0x12345678.
- MEM_RESP_ERR_EN on -> the write gets rsp_err=1 and reading 0x0 returns the prior value.
REQ-034 MEM_RESP_ERR_EN on: read 0x11 -> rsp_err=1, rsp_rdata=0; write 0x12 with 0xFFFFFFFF -> rsp_err=1 and word 4 is unchanged.
REQ-035 reset asserted (reset=0) in WAIT during a write to 0x20 (WAIT_CYCLES=3) -> no rsp_valid, req_ready=1 after reset releases, and word 8 is unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the memory responder: FSM state encoding and wait-counter width.
package riscv_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_e;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port word storage for mem_responder: synchronous write, combinational read, no reset.
module mem_array #(
  parameter int DEPTH_WORDS = 64,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Request/response memory target with programmable wait states.
// Optional access-fault reporting is compiled in with the MEM_RESP_ERR_EN macro.
module mem_responder
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  mem_resp_state_e  state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             write_reg;
  logic [31:0]      addr_reg;
  logic [31:0]      wdata_reg;
  logic             req_ready_reg;
  logic             rsp_valid_reg;
  logic [31:0]      rsp_rdata_reg;

  logic             cur_write;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_fault;
  logic             go_resp;
  logic             mem_we;
  logic [31:0]      mem_rdata;

  // With zero wait states the access completes on the accepting edge, so the
  // live request inputs must feed the array instead of the latched copy.
  always_comb begin
    cur_write = write_reg;
    cur_addr  = addr_reg;
    cur_wdata = wdata_reg;
    if (state_reg == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  assign cur_idx = cur_addr[IDX_W+1:2];
  assign go_resp = ((state_reg == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                   ((state_reg == WAIT) && (cnt_reg == '0));
  assign mem_we  = go_resp && cur_write && !cur_fault;

`ifdef MEM_RESP_ERR_EN
  logic err_reg;

  assign cur_fault = (cur_addr[1:0] != 2'b00) || (cur_addr >= 32'(4 * DEPTH_WORDS));
  assign rsp_err   = err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (go_resp) begin
      err_reg <= cur_fault;
    end
  end
`else
  logic unused_addr_bits;

  // Out-of-range addresses simply wrap onto the array.
  assign cur_fault        = 1'b0;
  assign rsp_err          = 1'b0;
  assign unused_addr_bits = ^{cur_addr[31:IDX_W+2], cur_addr[1:0]};
`endif

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (cur_idx),
    .wdata(cur_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      write_reg     <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            write_reg     <= req_write;
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
            req_ready_reg <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_reg <= RESP;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (go_resp) begin
        rsp_valid_reg <= 1'b1;
        rsp_rdata_reg <= (cur_write || cur_fault) ? 32'h0 : mem_rdata;
      end
    end
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder with three instances at 1, 0 and 3 wait states.
module tb_mem_responder;

  localparam int N = 3;
`ifdef MEM_RESP_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [N];
  logic        req_write [N];
  logic [31:0] req_addr  [N];
  logic [31:0] req_wdata [N];
  logic        req_ready [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err   [N];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      mem_responder #(
        .DEPTH_WORDS(64),
        .WAIT_CYCLES(gi == 0 ? 1 : (gi == 1 ? 0 : 3))
      ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid[gi]),
        .req_write(req_write[gi]),
        .req_addr (req_addr[gi]),
        .req_wdata(req_wdata[gi]),
        .req_ready(req_ready[gi]),
        .rsp_valid(rsp_valid[gi]),
        .rsp_ready(rsp_ready[gi]),
        .rsp_rdata(rsp_rdata[gi]),
        .rsp_err  (rsp_err[gi])
      );
    end
  endgenerate

  function automatic int wc(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  bit   prev_v [N];
  int   first  [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: pops one expectation per response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int k = 0; k < N; k++) prev_v[k] = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (rsp_valid[k] && !prev_v[k]) first[k] = cyc;
        prev_v[k] = rsp_valid[k];
        if (rsp_valid[k] && rsp_ready[k]) begin
          if (sb.size() == 0 || sb[0].dut != k) begin
            chk($sformatf("spurious_rsp_dut%0d", k), 1'b0, rsp_rdata[k], 32'h0);
          end else begin
            e = sb.pop_front();
            $display("rsp dut%0d cyc=%0d rdata=0x%08h err=%0b (exp 0x%08h err=%0b)",
                     k, cyc, rsp_rdata[k], rsp_err[k], e.rdata, e.err);
            chk($sformatf("rdata_dut%0d", k), rsp_rdata[k] === e.rdata, rsp_rdata[k], e.rdata);
            chk($sformatf("err_dut%0d", k), rsp_err[k] === e.err, 32'(rsp_err[k]), 32'(e.err));
            chk($sformatf("req_ready_in_resp_dut%0d", k), req_ready[k] === 1'b0, 32'(req_ready[k]), 32'h0);
            if (e.lat)
              chk($sformatf("latency_dut%0d", k), first[k] == e.acc + wc(k) + 1,
                  32'(first[k] - e.acc), 32'(wc(k) + 1));
          end
        end
      end
    end
  end

  // Presents a request at posedge+1 and returns at posedge+1 after the accepting edge.
  task automatic issue(input int k, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input bit ee, input bit lat, input bit push,
                       output int acc);
    int n = 0;
    bit done = 1'b0;
    acc = -1;
    req_valid[k] = 1'b1;
    req_write[k] = wr;
    req_addr[k]  = a;
    req_wdata[k] = d;
    while (!done && n < 50) begin
      @(negedge clk);
      if (req_ready[k]) begin
        acc  = cyc;
        done = 1'b1;
        if (push) sb.push_back('{dut: k, rdata: er, err: ee, lat: lat, acc: cyc});
      end
      @(posedge clk);
      #1;
      n++;
    end
    req_valid[k] = 1'b0;
    if (!done) chk($sformatf("accept_timeout_dut%0d", k), 1'b0, 32'(n), 32'h0);
  endtask

  task automatic do_wr(input int k, input logic [31:0] a, input logic [31:0] d, input bit ee);
    int acc;
    issue(k, 1'b1, a, d, 32'h0, ee, 1'b1, 1'b1, acc);
  endtask

  task automatic do_rd(input int k, input logic [31:0] a, input logic [31:0] x, input bit ee);
    int acc;
    issue(k, 1'b0, a, 32'h0, x, ee, 1'b1, 1'b1, acc);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", sb.size() == 0, 32'(sb.size()), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w4;
    logic [31:0] hold;
    int          acc1, acc2, n;
    bit          saw;

    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      rsp_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_req_ready_dut%0d", k), req_ready[k] === 1'b1, 32'(req_ready[k]), 32'h1);
      chk($sformatf("rst_rsp_valid_dut%0d", k), rsp_valid[k] === 1'b0, 32'(rsp_valid[k]), 32'h0);
      chk($sformatf("rst_rsp_rdata_dut%0d", k), rsp_rdata[k] === 32'h0, rsp_rdata[k], 32'h0);
      chk($sformatf("rst_rsp_err_dut%0d", k), rsp_err[k] === 1'b0, 32'(rsp_err[k]), 32'h0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;

    // One wait state: basic write/read, wrap or fault, misaligned accesses.
    do_wr(0, 32'h10, 32'hDEADBEEF, 1'b0);
    do_rd(0, 32'h10, 32'hDEADBEEF, 1'b0);
    do_wr(0, 32'h0, 32'hCAFEF00D, 1'b0);
    do_wr(0, 32'h100, 32'h12345678, ERR_ON);
    do_rd(0, 32'h0, ERR_ON ? 32'hCAFEF00D : 32'h12345678, 1'b0);
    do_rd(0, 32'h11, ERR_ON ? 32'h0 : 32'hDEADBEEF, ERR_ON);
    do_wr(0, 32'h12, 32'hFFFFFFFF, ERR_ON);
    w4 = ERR_ON ? 32'hDEADBEEF : 32'hFFFFFFFF;
    do_rd(0, 32'h10, w4, 1'b0);
    do_wr(0, 32'hFC, 32'h89ABCDEF, 1'b0);
    do_rd(0, 32'hFC, 32'h89ABCDEF, 1'b0);
    drain();

    // Response back-pressure with an ignored request pulse.
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h10, 32'h0, w4, 1'b0, 1'b0, 1'b1, acc1);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", rsp_valid[0] === 1'b1, 32'(rsp_valid[0]), 32'h1);
    hold = rsp_rdata[0];
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("stall_valid", rsp_valid[0] === 1'b1, 32'(rsp_valid[0]), 32'h1);
      chk("stall_rdata", rsp_rdata[0] === hold, rsp_rdata[0], hold);
      chk("stall_req_ready", req_ready[0] === 1'b0, 32'(req_ready[0]), 32'h0);
    end
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after_rsp_ready", req_ready[0] === 1'b1, 32'(req_ready[0]), 32'h1);
    chk("valid_drop_after_rsp_ready", rsp_valid[0] === 1'b0, 32'(rsp_valid[0]), 32'h0);
    drain();
    do_rd(0, 32'h10, w4, 1'b0);
    drain();

    // Zero wait states: back-to-back reads and write-then-read.
    do_wr(1, 32'h10, 32'h0BADF00D, 1'b0);
    do_wr(1, 32'h14, 32'h600DCAFE, 1'b0);
    issue(1, 1'b0, 32'h10, 32'h0, 32'h0BADF00D, 1'b0, 1'b1, 1'b1, acc1);
    issue(1, 1'b0, 32'h14, 32'h0, 32'h600DCAFE, 1'b0, 1'b1, 1'b1, acc2);
    chk("throughput_w0", acc2 - acc1 == 2, 32'(acc2 - acc1), 32'h2);
    do_wr(1, 32'h18, 32'h13579BDF, 1'b0);
    do_rd(1, 32'h18, 32'h13579BDF, 1'b0);
    drain();

    // Three wait states: reset during WAIT aborts the write.
    do_wr(2, 32'h20, 32'hA5A5A5A5, 1'b0);
    do_rd(2, 32'h20, 32'hA5A5A5A5, 1'b0);
    drain();
    issue(2, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b0, 1'b0, acc1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", req_ready[2] === 1'b1, 32'(req_ready[2]), 32'h1);
    chk("abort_rsp_valid", rsp_valid[2] === 1'b0, 32'(rsp_valid[2]), 32'h0);
    reset = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[2]) saw = 1'b1;
    end
    chk("abort_no_response", !saw, 32'(saw), 32'h0);
    chk("abort_ready_after_release", req_ready[2] === 1'b1, 32'(req_ready[2]), 32'h1);
    @(posedge clk);
    #1;
    do_rd(2, 32'h20, 32'hA5A5A5A5, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
